// File: rtl/seg7_scan8_if.sv
// Display-side bundle for seg7_scan8: enable, BCD digits and decimal-point
// requests flow in; active-low anode/segment/dp drive flows out.
interface seg7_scan8_if;
    logic       en;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [3:0] dig4;
    logic [3:0] dig5;
    logic [3:0] dig6;
    logic [3:0] dig7;
    logic [7:0] dp_in;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output en, dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7, dp_in,
        input  an, seg, dp
    );

    modport slave (
        input  en, dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7, dp_in,
        output an, seg, dp
    );
endinterface

// File: rtl/seg7_scan8.sv
// Eight-digit multiplexed common-anode seven-segment driver. Digits are
// captured once per scan frame, leading zeros can be blanked, and each slot
// opens with a dark dead-time before its anode is enabled.
module seg7_scan8 #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEADTIME    = 2,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    seg7_scan8_if.slave  bus
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          first_q, first_d;
    logic [3:0]    snap_dig_q [8];
    logic [7:0]    snap_dp_q;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [3:0]    dig_in [8];
    logic          load;
    logic          in_dead;
    logic [7:0]    blank;
    logic          upper_zero;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // Gather the digit inputs into an indexable array
    always_comb begin
        dig_in[0] = bus.dig0;
        dig_in[1] = bus.dig1;
        dig_in[2] = bus.dig2;
        dig_in[3] = bus.dig3;
        dig_in[4] = bus.dig4;
        dig_in[5] = bus.dig5;
        dig_in[6] = bus.dig6;
        dig_in[7] = bus.dig7;
    end

    // A DEADTIME of zero has no dark window; kept out of the compare so the
    // unsigned "< 0" never appears
    if (DEADTIME > 0) begin : g_dead
        assign in_dead = (cnt_q < CW'(DEADTIME));
    end else begin : g_nodead
        assign in_dead = 1'b0;
    end

    // Scan counters, snapshot strobe and first-frame flag
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        first_d = first_q;
        load    = 1'b0;
        if (bus.en) begin
            load    = first_q || ((cnt_q == CNT_LAST) && (idx_q == 3'd7));
            first_d = 1'b0;
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Digit k is blank when it and every more-significant digit are zero
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            upper_zero = upper_zero && (snap_dig_q[3'(7 - i)] == 4'd0);
            if (BLANK_LZ && (i != 7)) begin
                blank[3'(7 - i)] = upper_zero;
            end
        end
    end

    // Next output pattern from the current scan position and snapshot
    always_comb begin
        an_d  = '1;
        seg_d = '1;
        dp_d  = 1'b1;
        if (bus.en && !first_q && !in_dead) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = blank[idx_q] ? 7'h7F : decode(snap_dig_q[idx_q]);
            dp_d  = ~snap_dp_q[idx_q];
        end
    end

    // State, snapshot and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            first_q   <= 1'b1;
            snap_dp_q <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                snap_dig_q[i] <= '0;
            end
            an_q      <= '1;
            seg_q     <= '1;
            dp_q      <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            if (load) begin
                snap_dp_q <= bus.dp_in;
                for (int unsigned i = 0; i < 8; i++) begin
                    snap_dig_q[i] <= dig_in[i];
                end
            end
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan8.sv
// Bench for seg7_scan8: two instances (leading-zero blanking on and off)
// share one stimulus and are compared every cycle against a frame-position
// model, with hand-computed pins at key points.
module tb_seg7_scan8;

    localparam int RD = 4;
    localparam int DT = 1;
    localparam int NF = 8 * RD;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] dig [8];
    logic [7:0] dp_in = 8'h00;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    logic [6:0] lit1 [8] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] lit0 [8] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40};

    always #5 clk = ~clk;

    seg7_scan8_if bus1();
    seg7_scan8_if bus0();

    assign bus1.en = en;     assign bus0.en = en;
    assign bus1.dig0 = dig[0]; assign bus0.dig0 = dig[0];
    assign bus1.dig1 = dig[1]; assign bus0.dig1 = dig[1];
    assign bus1.dig2 = dig[2]; assign bus0.dig2 = dig[2];
    assign bus1.dig3 = dig[3]; assign bus0.dig3 = dig[3];
    assign bus1.dig4 = dig[4]; assign bus0.dig4 = dig[4];
    assign bus1.dig5 = dig[5]; assign bus0.dig5 = dig[5];
    assign bus1.dig6 = dig[6]; assign bus0.dig6 = dig[6];
    assign bus1.dig7 = dig[7]; assign bus0.dig7 = dig[7];
    assign bus1.dp_in = dp_in; assign bus0.dp_in = dp_in;

    seg7_scan8 #(.REFRESH_DIV(RD), .DEADTIME(DT), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    seg7_scan8 #(.REFRESH_DIV(RD), .DEADTIME(DT), .BLANK_LZ(1'b0)) u_dut_nolz (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: dec = 7'h40; 4'd1: dec = 7'h79; 4'd2: dec = 7'h24;
            4'd3: dec = 7'h30; 4'd4: dec = 7'h19; 4'd5: dec = 7'h12;
            4'd6: dec = 7'h02; 4'd7: dec = 7'h78; 4'd8: dec = 7'h00;
            4'd9: dec = 7'h10; default: dec = 7'h3F;
        endcase
    endfunction

    // Model: position within the frame (enabled cycles since the frame start)
    // and the captured value as a 32-bit hex word
    int          m_pos   = 0;
    bit          m_first = 1'b1;
    logic [31:0] m_word  = '0;
    logic [7:0]  m_dp    = '0;
    logic [7:0]  e_an    = 8'hFF;
    logic [6:0]  e_seg1  = 7'h7F;
    logic [6:0]  e_seg0  = 7'h7F;
    logic        e_dp    = 1'b1;

    always @(posedge clk or negedge rst_n) begin : model
        int          slot;
        int          off;
        logic [31:0] upper;
        if (!rst_n) begin
            m_pos = 0; m_first = 1'b1; m_word = '0; m_dp = '0;
            e_an = 8'hFF; e_seg1 = 7'h7F; e_seg0 = 7'h7F; e_dp = 1'b1;
        end else begin
            slot = m_pos / RD;
            off  = m_pos % RD;
            if (!en || m_first || off < DT) begin
                e_an = 8'hFF; e_seg1 = 7'h7F; e_seg0 = 7'h7F; e_dp = 1'b1;
            end else begin
                upper  = m_word >> (4 * slot);
                e_an   = ~(8'd1 << slot);
                e_seg0 = dec(upper[3:0]);
                e_seg1 = (slot != 0 && upper == 32'd0) ? 7'h7F : dec(upper[3:0]);
                e_dp   = ~m_dp[slot];
            end
            if (en) begin
                if (m_first || m_pos == NF - 1) begin
                    m_word = {dig[7], dig[6], dig[5], dig[4], dig[3], dig[2], dig[1], dig[0]};
                    m_dp   = dp_in;
                end
                m_first = 1'b0;
                m_pos   = (m_pos + 1) % NF;
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("an",       bus1.an,           e_an);
            chk("seg",      {1'b0, bus1.seg},  {1'b0, e_seg1});
            chk("dp",       {7'b0, bus1.dp},   {7'b0, e_dp});
            chk("an_nolz",  bus0.an,           e_an);
            chk("seg_nolz", {1'b0, bus0.seg},  {1'b0, e_seg0});
            chk("dp_nolz",  {7'b0, bus0.dp},   {7'b0, e_dp});
        end
    end

    task automatic pin(input string nm, input logic [7:0] an, input logic [6:0] s1,
                       input logic [6:0] s0, input logic pdp);
        chk({nm, "_an"},      bus1.an,          an);
        chk({nm, "_seg"},     {1'b0, bus1.seg}, {1'b0, s1});
        chk({nm, "_seg_nolz"},{1'b0, bus0.seg}, {1'b0, s0});
        chk({nm, "_dp"},      {7'b0, bus1.dp},  {7'b0, pdp});
    endtask

    // One full frame; pins slot ps at its first lit cycle
    task automatic run_frame(input string nm, input int ps, input logic [6:0] s1,
                             input logic [6:0] s0, input logic pdp);
        logic [7:0] a;
        a = ~(8'd1 << ps);
        for (int p = 0; p < NF; p++) begin
            @(negedge clk);
            if (p == ps * RD + 1) pin(nm, a, s1, s0, pdp);
        end
    endtask

    initial begin
        logic [7:0] a;
        for (int i = 0; i < 8; i++) dig[i] = 4'd0;
        dig[0] = 4'd4; dig[1] = 4'd3; dig[2] = 4'd2; dig[3] = 4'd1;
        en = 1'b1;
        repeat (2) @(negedge clk);
        pin("reset", 8'hFF, 7'h7F, 7'h7F, 1'b1);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // First frame after reset: value 1234
        for (int s = 0; s < 8; s++) begin
            for (int o = 0; o < RD; o++) begin
                @(negedge clk);
                a = ~(8'd1 << s);
                if (o == 0) pin("f0_dead", 8'hFF, 7'h7F, 7'h7F, 1'b1);
                else        pin("f0_lit", a, lit1[s], lit0[s], 1'b1);
                if (s == 2 && o == 0) begin
                    dig[0] = 4'd7;
                    dig[5] = 4'd6;
                end
            end
        end

        // Mid-frame change lands in the next frame
        for (int i = 0; i < 8; i++) dig[i] = 4'd0;
        run_frame("f1_d0", 0, 7'h78, 7'h78, 1'b1);

        // All zeros; next value 1005 with dp on digit 2
        dig[0] = 4'd5; dig[3] = 4'd1; dp_in = 8'h04;
        run_frame("f2_zero", 3, 7'h7F, 7'h40, 1'b1);

        dig[3] = 4'd12;
        run_frame("f3_dp", 2, 7'h40, 7'h40, 1'b0);
        run_frame("f4_minus", 3, 7'h3F, 7'h3F, 1'b1);

        // Enable gating at idx=3, cnt=2
        repeat (14) @(negedge clk);
        en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            pin("en_low", 8'hFF, 7'h7F, 7'h7F, 1'b1);
        end
        en = 1'b1;
        @(negedge clk); pin("resume_c2", 8'hF7, 7'h3F, 7'h3F, 1'b1);
        @(negedge clk); pin("resume_c3", 8'hF7, 7'h3F, 7'h3F, 1'b1);
        @(negedge clk); pin("resume_dead", 8'hFF, 7'h7F, 7'h7F, 1'b1);
        @(negedge clk); pin("resume_s4", 8'hEF, 7'h7F, 7'h40, 1'b1);

        // Asynchronous reset in the middle of slot 5
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_an", bus1.an, 8'hFF);
        chk("async_an_nolz", bus0.an, 8'hFF);
        chk("async_seg", {1'b0, bus1.seg}, 8'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        for (int o = 0; o < RD; o++) begin
            @(negedge clk);
            if (o == 0) pin("rst_dead", 8'hFF, 7'h7F, 7'h7F, 1'b1);
            else        pin("rst_s0", 8'hFE, 7'h12, 7'h12, 1'b1);
        end
        repeat (NF) @(negedge clk);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan8.md
# seg7_scan8

Time-multiplexed driver for an 8-digit common-anode seven-segment display, placed directly downstream of the 32-bit binary-to-BCD converter in the factorial calculator datapath. It takes the eight BCD digits (dig0 = least significant) and drives one anode at a time with the matching segment pattern. Digit values are snapshotted once per scan frame so that a display never mixes digits from two different values. Leading zeros are blanked, and an anode dead-time is inserted between slots to suppress ghosting.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; legal range ≥ 2.
- DEADTIME, 2: cycles at the start of each slot with all anodes off; legal range 0 … REFRESH_DIV-1.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 shows all eight digits.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  display enable.
- dig0 … dig7  in  4 each  BCD digits; dig0 is the least significant.
- dp_in  in  8  decimal-point request per digit; active-high; bit k maps to digit k.
- an  out  8  anode enables; active-low; bit k drives digit k.
- seg  out  7  segments {g,f,e,d,c,b,a}; active-low.
- dp  out  1  decimal-point segment; active-low.

## Operation
- **State**
  - cnt: 0 … REFRESH_DIV-1.
  - idx: 0 … 7.
  - snap_dig[0:7], snap_dp[7:0].
  - first flag: set by reset.
- **Counters (only while en=1)**
  - cnt increments each cycle; at REFRESH_DIV-1 it wraps to 0 and idx increments.
  - idx wraps 7 → 0.
  - While en=0, cnt and idx hold.
- **Snapshot**
  - Load all dig inputs and dp_in on the edge where en=1, cnt=REFRESH_DIV-1 and idx=7 (frame boundary).
  - Also load on the first en=1 edge after reset; this clears first.
  - Inputs are ignored at all other times.
- **Blanking**
  - Digit k (k ≥ 1) is blanked when BLANK_LZ=1 and snap_dig[k..7] are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives seg=7'h7F, but its anode and dp still operate.
- **Decode (active-low)**
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Codes 10–15 produce 3F (minus sign, g only).
- **Output formation (from current state)**
  - Outputs are dark (an=FF, seg=7F, dp=1) when any of these holds: en=0, first=1, or cnt < DEADTIME.
  - Otherwise:
    - an = ~(1<<idx)
    - seg = decode or blank of snap_dig[idx]
    - dp = ~snap_dp[idx]
- **Reset values**
  - an=8'hFF, seg=7'h7F, dp=1.
  - cnt=0, idx=0, snapshot all zero, first=1.
- **Mid-operation reset**
  - Asynchronous return to the reset values, regardless of cnt/idx.

## Timing
- All outputs are registered: the outputs in cycle t+1 reflect cnt, idx and snapshot at cycle t.
- Total output latency from a snapshot edge to the first visible digit-0 pattern is DEADTIME+1 cycles.
- A slot lasts exactly REFRESH_DIV enabled cycles; a frame lasts 8·REFRESH_DIV enabled cycles.
- With DEADTIME=0, anodes switch with no dark cycle between slots.
- Dropping en: outputs go dark on the next edge.
- Raising en: counting resumes from the held cnt/idx, and no extra snapshot is taken (except the first one after reset).
- Input changes inside a frame are invisible until the next frame boundary.
- If the input changes on the same edge as the snapshot, the value sampled on that edge is used.

## Test plan
- **Reset/initial frame.** REFRESH_DIV=4, DEADTIME=1, en=1, value digits 0,0,0,0,1,2,3,4 (dig7…dig0). Release rst_n.
  - Required: after the first snapshot, slot 0 is dark for 1 cycle, then an=FE with seg=19 ('4') for 3 cycles.
  - Then slot 1 shows an=FD, seg=30; slot 2 seg=24; slot 3 seg=79.
  - Slots 4–7 show their anode with seg=7F.
- **Frame atomicity.** Change dig0 from 4 to 7 while idx=2.
  - Required: digit 0 stays 19 for the rest of the frame and shows 78 only in the next frame.
- **Zero value.** All digits = 0.
  - Required: digit 0 shows 40; digits 1–7 show 7F.
  - With BLANK_LZ=0, all eight digits show 40.
- **Internal zero and dp.** Digits 0,0,0,0,1,0,0,5 with dp_in=8'h04.
  - Required: digits 1 and 2 show 40 (not blanked).
  - Digit 2 drives dp=0; all other slots drive dp=1.
  - Code 12 injected on dig3 shows 3F.
- **Enable gating.** Deassert en at idx=3, cnt=2 for 10 cycles, then reassert.
  - Required: an=FF, seg=7F, dp=1 while en is low.
  - Scanning resumes at idx=3, cnt=2, and the slot finishes its remaining cycles.
- **Asynchronous reset mid-slot.** Pull rst_n low at idx=5 between clock edges.
  - Required: an=FF immediately without waiting for a clock edge.
  - After release, the first snapshot is retaken and scanning restarts at idx=0.
